// File: rtl/common.sv
// ------------------------------------------------------------------
// common: basic shared scalar types.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package common;
  typedef logic [31:0] u32;
endpackage

`default_nettype wire

// File: rtl/imem_responder_pkg.sv
// ------------------------------------------------------------------
// imem_responder_pkg: FSM state encoding and address check helper.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package imem_responder_pkg;
  import common::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // limit is the byte size of the array, carried at 33 bits so 4*DEPTH never wraps.
  function automatic logic addr_bad(input u32 addr, input logic [32:0] limit);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction
endpackage

`default_nettype wire

// File: rtl/pipes.sv
// ------------------------------------------------------------------
// pipes: instruction-bus request/response record types.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pipes;
  import common::*;

  typedef struct packed {
    logic valid;
    u32   addr;
  } ibus_req_t;

  typedef struct packed {
    logic valid;
    u32   data;
    logic err;
  } ibus_resp_t;
endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ------------------------------------------------------------------
// imem_array: word storage with one synchronous read and one write port.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imem_array
  import common::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rd_en,
  input  logic            i_rd_clr,
  input  logic [IDXW-1:0] i_rd_idx,
  output u32              o_rd_data,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  u32              i_wr_data
);

  u32 r_mem [DEPTH];
  u32 r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Read-before-write: a same-edge write to the read index is seen only by later reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_clr ? '0 : r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ------------------------------------------------------------------
// imem_responder: single-outstanding instruction fetch responder with fixed latency.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module imem_responder
  import common::*;
  import pipes::*;
  import imem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  u32   req_addr,
  output logic req_ready,
  output logic resp_valid,
  output u32   resp_data,
  output logic resp_err,
  input  logic resp_ready,
  input  logic ld_en,
  input  u32   ld_addr,
  input  u32   ld_data
);

  localparam int          c_IDXW       = $clog2(DEPTH);
  localparam logic [32:0] c_ADDR_LIMIT = {1'b0, 32'(DEPTH)} << 2;
  localparam logic [3:0]  c_CNT_INIT   = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit          c_LAT1       = (LATENCY == 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  u32         r_addr;
  logic       r_err;

  ibus_req_t  w_req;
  ibus_resp_t w_resp;
  logic       w_accept;
  logic       w_enter_resp;
  u32         w_rd_addr;
  logic       w_rd_bad;
  u32         w_rd_data;
  logic       w_ld_ok;

  assign w_req = '{valid: req_valid, addr: req_addr};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        w_accept  = w_req.valid;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        req_ready = resp_ready;
        if (resp_ready) begin
          w_accept = w_req.valid;
          if (!w_req.valid) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = c_LAT1 ? S_RESP : S_WAIT;
      w_cnt_nxt   = c_CNT_INIT;
    end
  end

  // With LATENCY=1 the read happens on the accepting edge, before r_addr holds the address.
  assign w_enter_resp = (w_state_nxt == S_RESP) && ((r_state != S_RESP) || w_accept);
  assign w_rd_addr    = (c_LAT1 && w_accept) ? w_req.addr : r_addr;
  assign w_rd_bad     = addr_bad(w_rd_addr, c_ADDR_LIMIT);
  assign w_ld_ok      = ({1'b0, ld_addr} < c_ADDR_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= w_req.addr;
      end
      if (w_enter_resp) begin
        r_err <= w_rd_bad;
      end
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .IDXW  (c_IDXW)
  ) u_array (
    .clk       (clk),
    .rst       (reset),
    .i_rd_en   (w_enter_resp),
    .i_rd_clr  (w_rd_bad),
    .i_rd_idx  (w_rd_addr[c_IDXW+1:2]),
    .o_rd_data (w_rd_data),
    .i_wr_en   (ld_en && w_ld_ok),
    .i_wr_idx  (ld_addr[c_IDXW+1:2]),
    .i_wr_data (ld_data)
  );

  assign w_resp = '{valid: (r_state == S_RESP), data: w_rd_data, err: r_err};

  assign resp_valid = w_resp.valid;
  assign resp_data  = w_resp.data;
  assign resp_err   = w_resp.err;

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ------------------------------------------------------------------
// tb_imem_responder: vector table, corner sequences and randomized fetches.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_imem_responder;
  import common::*;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam u32 LIMIT   = 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, resp_valid, resp_err, resp_ready, ld_en;
  u32   req_addr, resp_data, ld_addr, ld_data;

  int n_tests = 0;
  int n_fail  = 0;
  u32 mem_model [DEPTH];

  typedef struct {
    u32   addr;
    logic err;
    u32   data;
  } vec_t;
  vec_t vecs [8];

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input u32 a, input u32 dat);
    ld_en = 1'b1; ld_addr = a; ld_data = dat;
    step();
    ld_en = 1'b0;
    if (a < LIMIT) mem_model[a / 4] = dat;
  endtask

  // Issue one request, stall the response for 'stall' cycles, then consume it.
  task automatic do_req(input u32 addr, input int stall, output u32 d, output logic e, output int lat);
    int n;
    req_valid = 1'b1; req_addr = addr; resp_ready = (stall == 0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    lat = n; d = resp_data; e = resp_err;
    for (int k = 0; k < stall; k++) begin
      step();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, d);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
  endtask

  initial begin
    u32   d, a, exp_d;
    logic e, exp_e, saw;
    int   lat, m;

    vecs[0] = '{addr: 32'h0000_0000, err: 1'b0, data: 32'h0000_0013};
    vecs[1] = '{addr: 32'h0000_0004, err: 1'b0, data: 32'h1000_0001};
    vecs[2] = '{addr: 32'h0000_00FC, err: 1'b0, data: 32'h1000_003F};
    vecs[3] = '{addr: 32'h0000_0002, err: 1'b1, data: 32'h0000_0000};
    vecs[4] = '{addr: 32'h0000_0100, err: 1'b1, data: 32'h0000_0000};
    vecs[5] = '{addr: 32'h0000_0009, err: 1'b1, data: 32'h0000_0000};
    vecs[6] = '{addr: 32'hFFFF_FFFC, err: 1'b1, data: 32'h0000_0000};
    vecs[7] = '{addr: 32'h0000_0080, err: 1'b0, data: 32'h1000_0020};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    step(); step();
    reset = 1'b0;

    load(32'h0, 32'h0000_0013);
    for (int i = 1; i < DEPTH; i++) load(u32'(4 * i), 32'h1000_0000 + u32'(i));

    // Contents must survive a reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].addr, 0, d, e, lat);
      chk("vec_data", d, vecs[i].data);
      chk("vec_err", 32'(e), 32'(vecs[i].err));
      chk("vec_latency", 32'(lat), 32'(LATENCY));
      chk("vec_idle_after", 32'(resp_valid), 32'd0);
    end

    // Stall the response for 5 cycles, then return to IDLE.
    do_req(32'h8, 5, d, e, lat);
    chk("stall_data", d, 32'h1000_0002);
    chk("stall_released_valid", 32'(resp_valid), 32'd0);
    chk("stall_released_ready", 32'(req_ready), 32'd1);

    // Back-to-back: second request held until the first response handshake.
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b1;
    step();
    req_addr = 32'h8;
    m = 1;
    while (!resp_valid && m < 20) begin step(); m++; end
    chk("b2b_lat1", 32'(m), 32'(LATENCY));
    chk("b2b_data1", resp_data, 32'h1000_0001);
    chk("b2b_handshake_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_gap_valid_low", 32'(resp_valid), 32'd0);
    m = 1;
    while (!resp_valid && m < 20) begin step(); m++; end
    chk("b2b_spacing", 32'(m), 32'(LATENCY));
    chk("b2b_data2", resp_data, 32'h1000_0002);
    chk("b2b_err2", 32'(resp_err), 32'd0);
    step();
    chk("b2b_idle", 32'(resp_valid), 32'd0);

    // Load to the read index on the RESP-entry edge returns the old word.
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hCAFE_F00D;
    step();
    ld_en = 1'b0;
    mem_model[1] = 32'hCAFE_F00D;
    chk("collide_valid", 32'(resp_valid), 32'd1);
    chk("collide_old_word", resp_data, 32'h1000_0001);
    step();
    do_req(32'h4, 0, d, e, lat);
    chk("collide_new_word", d, 32'hCAFE_F00D);

    // Reset while WAIT aborts the request.
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_data", resp_data, 32'd0);
    step();
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (resp_valid) saw = 1'b1;
    end
    chk("abort_no_response", 32'(saw), 32'd0);
    do_req(32'h8, 0, d, e, lat);
    chk("abort_fresh_data", d, 32'h1000_0002);
    chk("abort_fresh_latency", 32'(lat), 32'(LATENCY));

    // Out-of-range loads are dropped and must not alias into the array.
    load(LIMIT, 32'hBAD0_BAD0);
    load(32'hFFFF_FFFC, 32'hBAD1_BAD1);
    do_req(32'h0, 0, d, e, lat);
    chk("oor_load_word0", d, 32'h0000_0013);
    do_req(32'hFC, 0, d, e, lat);
    chk("oor_load_word63", d, 32'h1000_003F);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) load($urandom_range(LIMIT, 32'hFFFF_FFFF), $urandom);
        else load(u32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      end
      case ($urandom_range(0, 9))
        6, 7:    a = u32'($urandom_range(0, DEPTH - 1)) * 4 + u32'($urandom_range(1, 3));
        8:       a = $urandom_range(LIMIT, 32'hFFFF_FFFF);
        9:       a = LIMIT;
        default: a = u32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      exp_e = ((a % 4) != 0) || (a >= LIMIT);
      exp_d = exp_e ? 32'd0 : mem_model[a / 4];
      do_req(a, $urandom_range(0, 3), d, e, lat);
      chk("rand_data", d, exp_d);
      chk("rand_err", 32'(e), 32'(exp_e));
      chk("rand_latency", 32'(lat), 32'(LATENCY));
      chk("rand_idle_after", 32'(resp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
